// File: rtl/csr_counters.sv
`default_nettype none
// ============================================================================
// csr_counters : machine-mode counter CSR bank (mcycle, minstret, N_HPM hpm
//                counters, mcountinhibit, mhpmevent, user read-only shadows).
//                Optional CSR_CNT_OVF_EN adds sticky hpm overflow flags + ovf_irq.
// Revision     : 1.0
// ============================================================================
module csr_counters #(
  parameter int N_HPM    = 4,
  parameter int N_EVENTS = 8,
  parameter int CNT_W    = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wen,
  input  logic [11:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic                is_instret,
  input  logic                halt,
  input  logic [N_EVENTS-1:0] events,
  output logic                ovf_irq
);

  localparam int          EV_W     = $clog2(N_EVENTS + 1);
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << N_HPM) - 32'h1) << 3);

  logic [CNT_W-1:0] mcycle;
  logic [CNT_W-1:0] minstret;
  logic [31:0]      inhibit;
  logic [CNT_W-1:0] hpm_cnt [N_HPM];
  logic [EV_W-1:0]  hpm_sel [N_HPM];
  logic [N_HPM-1:0] hpm_of;
  logic [11:0]      base;

  // A write to either half beats the increment in the same cycle.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic wr_lo, input logic wr_hi,
                                                input logic inc, input logic [31:0] wd);
    logic [63:0] t;
    t = 64'(cur);
    if (wr_lo)      t[31:0]  = wd;
    else if (wr_hi) t[63:32] = wd;
    else if (inc)   return cur + CNT_W'(1);
    return t[CNT_W-1:0];
  endfunction

  function automatic logic [31:0] hi_half(input logic [CNT_W-1:0] v);
    logic [63:0] t;
    t = 64'(v);
    return t[63:32];
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcycle   <= '0;
      minstret <= '0;
      inhibit  <= '0;
    end else begin
      mcycle   <= cnt_next(mcycle, wen && addr == 12'hB00, wen && addr == 12'hB80,
                           !halt && !inhibit[0], wdata);
      minstret <= cnt_next(minstret, wen && addr == 12'hB02, wen && addr == 12'hB82,
                           is_instret && !inhibit[2], wdata);
      if (wen && addr == 12'h320) inhibit <= wdata & INH_MASK;
    end
  end

  for (genvar i = 0; i < N_HPM; i++) begin : g_hpm
    localparam logic [11:0] LO_A = 12'hB03 + 12'(i);
    localparam logic [11:0] HI_A = 12'hB83 + 12'(i);
    localparam logic [11:0] EV_A = 12'h323 + 12'(i);

    logic [CNT_W-1:0] cnt;
    logic [EV_W-1:0]  sel;
    logic             hit;
    logic             inc;
    logic             wr_lo;
    logic             wr_hi;
    logic             wr_ev;

    // Selector values 0 and above N_EVENTS never match any event.
    always_comb begin
      hit = 1'b0;
      for (int j = 0; j < N_EVENTS; j++) begin
        if (sel == EV_W'(j + 1) && events[j]) hit = 1'b1;
      end
    end

    assign wr_lo = wen && addr == LO_A;
    assign wr_hi = wen && addr == HI_A;
    assign wr_ev = wen && addr == EV_A;
    assign inc   = hit && !inhibit[3+i];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
        sel <= '0;
      end else begin
        cnt <= cnt_next(cnt, wr_lo, wr_hi, inc, wdata);
        if (wr_ev) sel <= wdata[EV_W-1:0];
      end
    end

    assign hpm_cnt[i] = cnt;
    assign hpm_sel[i] = sel;

`ifdef CSR_CNT_OVF_EN
    logic of;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                                 of <= 1'b0;
      else if (wr_ev)                               of <= wdata[31];
      else if (inc && !wr_lo && !wr_hi && (&cnt))   of <= 1'b1;
    end
    assign hpm_of[i] = of;
`else
    assign hpm_of[i] = 1'b0;
`endif
  end

  // User shadows on page C alias the machine counters on page B.
  assign base = (addr[11:8] == 4'hC) ? {4'hB, addr[7:0]} : addr;

  always_comb begin
    rdata = '0;
    case (base)
      12'hB00: rdata = mcycle[31:0];
      12'hB80: rdata = hi_half(mcycle);
      12'hB02: rdata = minstret[31:0];
      12'hB82: rdata = hi_half(minstret);
      12'h320: rdata = inhibit;
      default: ;
    endcase
    for (int i = 0; i < N_HPM; i++) begin
      if (base == 12'hB03 + 12'(i)) rdata = hpm_cnt[i][31:0];
      if (base == 12'hB83 + 12'(i)) rdata = hi_half(hpm_cnt[i]);
      if (base == 12'h323 + 12'(i)) rdata = {hpm_of[i], 31'(hpm_sel[i])};
    end
  end

`ifdef CSR_CNT_OVF_EN
  assign ovf_irq = |hpm_of;
`else
  assign ovf_irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csr_counters.sv
`default_nettype none
// ============================================================================
// tb_csr_counters : scoreboard bench for csr_counters with a behavioural model.
// Revision        : 1.0
// ============================================================================
module tb_csr_counters;
  localparam int N_HPM    = 4;
  localparam int N_EVENTS = 6;
  localparam int CNT_W    = 48;
  localparam int EV_W     = $clog2(N_EVENTS + 1);
  localparam longint unsigned CMAX = (64'd1 << CNT_W) - 64'd1;
`ifdef CSR_CNT_OVF_EN
  localparam logic [31:0] OFK = 32'h8000_0001;
`else
  localparam logic [31:0] OFK = 32'h0000_0001;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic wen = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic is_instret = 1'b0;
  logic halt = 1'b0;
  logic [N_EVENTS-1:0] events = '0;
  logic ovf_irq;

  csr_counters #(.N_HPM(N_HPM), .N_EVENTS(N_EVENTS), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .wen(wen), .addr(addr), .wdata(wdata),
    .rdata(rdata), .is_instret(is_instret), .halt(halt), .events(events),
    .ovf_irq(ovf_irq)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    string       nm;
  } exp_t;
  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  longint unsigned m_cyc, m_ins;
  longint unsigned m_hpm [N_HPM];
  int unsigned     m_sel [N_HPM];
  bit              m_of  [N_HPM];
  logic [31:0]     m_inh;

  function automatic void m_reset();
    m_cyc = 0; m_ins = 0; m_inh = '0;
    for (int i = 0; i < N_HPM; i++) begin m_hpm[i] = 0; m_sel[i] = 0; m_of[i] = 0; end
  endfunction

  function automatic logic [31:0] inh_mask();
    logic [31:0] m;
    m = '0; m[0] = 1'b1; m[2] = 1'b1;
    for (int i = 0; i < N_HPM; i++) m[3+i] = 1'b1;
    return m;
  endfunction

  function automatic bit m_irq();
    bit r;
    r = 0;
    for (int i = 0; i < N_HPM; i++) r |= m_of[i];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [11:0] b;
    longint unsigned v;
    bit hit;
    int off;
    b = a;
    if (a[11:8] == 4'hC) b[11:8] = 4'hB;
    hit = 0; v = 0; off = int'(b[6:0]);
    if (b[11:8] == 4'hB) begin
      if (off == 0)                        begin v = m_cyc; hit = 1; end
      else if (off == 2)                   begin v = m_ins; hit = 1; end
      else if (off >= 3 && off < 3 + N_HPM) begin v = m_hpm[off-3]; hit = 1; end
    end
    if (hit) return b[7] ? v[63:32] : v[31:0];
    if (a == 12'h320) return m_inh;
    for (int i = 0; i < N_HPM; i++)
      if (int'(a) == 'h323 + i) return {m_of[i], 31'(m_sel[i])};
    return '0;
  endfunction

  function automatic longint unsigned upd(input longint unsigned v, input bit wl, input bit wh,
                                          input logic [31:0] d, input bit inc, output bit wrap);
    wrap = 0;
    if (wl) return (v & 64'hFFFF_FFFF_0000_0000) | {32'd0, d};
    if (wh) return ({d, 32'd0} | (v & 64'h0000_0000_FFFF_FFFF)) & CMAX;
    if (inc) begin
      wrap = (v == CMAX);
      return (v + 64'd1) & CMAX;
    end
    return v;
  endfunction

  function automatic bit cw(input bit w, input logic [11:0] a, input bit hi, input int idx);
    return w && a[11:8] == 4'hB && a[7] == hi && int'(a[6:0]) == idx;
  endfunction

  function automatic void m_step(input bit w, input logic [11:0] a, input logic [31:0] d,
                                 input bit ins, input bit h, input logic [N_EVENTS-1:0] ev);
    bit inc_c, inc_i, wrap;
    bit inc_h [N_HPM];
    inc_c = !h && !m_inh[0];
    inc_i = ins && !m_inh[2];
    for (int i = 0; i < N_HPM; i++) begin
      inc_h[i] = 0;
      if (m_sel[i] >= 1 && m_sel[i] <= N_EVENTS)
        inc_h[i] = ev[m_sel[i]-1] && !m_inh[3+i];
    end
    m_cyc = upd(m_cyc, cw(w, a, 0, 0), cw(w, a, 1, 0), d, inc_c, wrap);
    m_ins = upd(m_ins, cw(w, a, 0, 2), cw(w, a, 1, 2), d, inc_i, wrap);
    for (int i = 0; i < N_HPM; i++) begin
      m_hpm[i] = upd(m_hpm[i], cw(w, a, 0, 3 + i), cw(w, a, 1, 3 + i), d, inc_h[i], wrap);
`ifdef CSR_CNT_OVF_EN
      if (wrap) m_of[i] = 1;
`endif
    end
    if (w && a == 12'h320) m_inh = d & inh_mask();
    for (int i = 0; i < N_HPM; i++) begin
      if (w && int'(a) == 'h323 + i) begin
        m_sel[i] = d & ((32'd1 << EV_W) - 1);
`ifdef CSR_CNT_OVF_EN
        m_of[i] = d[31];
`endif
      end
    end
  endfunction

  // One clock cycle: drive, queue the expected read, then advance the model.
  task automatic cyc(input bit w, input logic [11:0] a, input logic [31:0] d, input bit ins,
                     input bit h, input logic [N_EVENTS-1:0] ev, input string nm,
                     input bit use_k = 0, input logic [31:0] k = '0);
    exp_t e;
    wen = w; addr = a; wdata = d; is_instret = ins; halt = h; events = ev;
    e.rd = use_k ? k : m_read(a);
    e.irq = m_irq();
    e.nm = nm;
    sbq.push_back(e);
    @(posedge clock);
    m_step(w, a, d, ins, h, ev);
    #1;
  endtask

  // Reset held low: any write is ignored and every read is zero.
  task automatic rst_read(input logic [11:0] a, input string nm);
    exp_t e;
    wen = 1'b1; addr = a; wdata = 32'hA5A5_A5A5; is_instret = 1'b1; halt = 1'b0;
    events = '1;
    e.rd = '0; e.irq = 1'b0; e.nm = nm;
    sbq.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic reset_burst();
    reset_n = 1'b0;
    m_reset();
    rst_read(12'hB00, "rst_b00");
    rst_read(12'hB80, "rst_b80");
    rst_read(12'hB03, "rst_b03");
    rst_read(12'h320, "rst_inh");
    rst_read(12'h323, "rst_sel");
    rst_read(12'hC02, "rst_c02");
    wen = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin : mon
    exp_t me;
    forever begin
      @(negedge clock);
      if (sbq.size() != 0) begin
        me = sbq.pop_front();
        checks++;
        if (rdata !== me.rd) begin
          failures++;
          $display("FAIL %s rdata actual=%08h required=%08h t=%0t", me.nm, rdata, me.rd, $time);
        end
        checks++;
        if (ovf_irq !== me.irq) begin
          failures++;
          $display("FAIL %s ovf_irq actual=%b required=%b t=%0t", me.nm, ovf_irq, me.irq, $time);
        end
      end
    end
  end

  function automatic logic [11:0] pick_addr();
    int r;
    r = $urandom_range(0, 15);
    case (r)
      0: return 12'hB00;
      1: return 12'hB80;
      2: return 12'hB02;
      3: return 12'hB82;
      4: return 12'hB03 + 12'($urandom_range(0, N_HPM));
      5: return 12'hB83 + 12'($urandom_range(0, N_HPM));
      6: return 12'hC00 + 12'($urandom_range(0, 3 + N_HPM));
      7: return 12'hC80 + 12'($urandom_range(0, 3 + N_HPM));
      8, 9: return 12'h323 + 12'($urandom_range(0, N_HPM));
      10: return 12'h320;
      11: return 12'h7C0;
      12: return 12'(32'($urandom));
      default: return 12'hB03 + 12'($urandom_range(0, N_HPM - 1));
    endcase
  endfunction

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFF;
      1: return 32'hFFFF_FFFE;
      2: return 32'($urandom_range(0, 7));
      3: return {1'b1, 28'd0, 3'($urandom_range(0, 7))};
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Idle count after reset
    repeat (10) cyc(0, 12'hB00, 0, 0, 0, '0, "idle");
    cyc(0, 12'hB00, 0, 0, 1, '0, "idle_b00", 1, 32'd10);
    cyc(0, 12'hB02, 0, 0, 1, '0, "idle_b02", 1, 32'd0);
    cyc(0, 12'hC00, 0, 0, 1, '0, "idle_c00", 1, 32'd10);
    for (int i = 0; i < N_HPM; i++) cyc(0, 12'hB03 + 12'(i), 0, 0, 1, '0, "idle_hpm", 1, 32'd0);

    // Halt freezes mcycle; carry into the high half
    cyc(1, 12'hB80, 32'h1, 0, 0, '0, "wr_b80");
    cyc(1, 12'hB00, 32'hFFFF_FFFE, 0, 1, '0, "wr_b00");
    repeat (3) cyc(0, 12'hB00, 0, 0, 1, '0, "halt_b00", 1, 32'hFFFF_FFFE);
    repeat (3) cyc(0, 12'hB00, 0, 0, 0, '0, "run_b00");
    cyc(0, 12'hB00, 0, 0, 1, '0, "carry_b00", 1, 32'h1);
    cyc(0, 12'hB80, 0, 0, 1, '0, "carry_b80", 1, 32'h2);

    // Event selection and inhibit
    cyc(1, 12'h323, 32'h2, 0, 1, '0, "wr_sel");
    repeat (5) cyc(0, 12'hB03, 0, 0, 1, N_EVENTS'(2), "ev1");
    repeat (4) cyc(0, 12'hB03, 0, 0, 1, N_EVENTS'(1), "ev0");
    cyc(0, 12'hB03, 0, 0, 1, '0, "b03_five", 1, 32'd5);
    cyc(1, 12'h320, 32'h8, 0, 1, '0, "wr_inh");
    repeat (3) cyc(0, 12'hB03, 0, 0, 1, N_EVENTS'(2), "ev1_inh");
    cyc(0, 12'hB03, 0, 0, 1, '0, "b03_inh", 1, 32'd5);

    // minstret write beats the same-cycle retire
    cyc(1, 12'hB02, 32'd100, 1, 1, '0, "wr_b02");
    cyc(0, 12'hB02, 0, 1, 1, '0, "instret_k1", 1, 32'd100);
    cyc(0, 12'hB02, 0, 1, 1, '0, "instret_k2", 1, 32'd101);

    // hpm wrap and overflow flag
    cyc(1, 12'h320, 32'h0, 0, 1, '0, "clr_inh");
    cyc(1, 12'h323, 32'h1, 0, 1, '0, "sel_ev0");
    cyc(1, 12'hB83, 32'hFFFF_FFFF, 0, 1, '0, "wr_b83");
    cyc(1, 12'hB03, 32'hFFFF_FFFF, 0, 1, '0, "wr_b03");
    cyc(0, 12'hB03, 0, 0, 1, N_EVENTS'(1), "ovf_pulse", 1, 32'hFFFF_FFFF);
    cyc(0, 12'hB03, 0, 0, 1, '0, "ovf_wrap", 1, 32'h0);
    cyc(0, 12'h323, 0, 0, 1, '0, "of_read", 1, OFK);
    cyc(1, 12'h323, 32'h1, 0, 1, '0, "of_clr", 1, OFK);
    cyc(0, 12'h323, 0, 0, 1, '0, "of_after", 1, 32'h1);

    // Shadow write ignored, unmapped read zero
    cyc(1, 12'hC00, 32'd5, 0, 1, '0, "wr_shadow");
    cyc(0, 12'hB00, 0, 0, 1, '0, "b00_unch");
    cyc(0, 12'h7C0, 0, 0, 1, '0, "unmapped", 1, 32'h0);

    repeat (4) cyc(0, 12'hB00, 0, 1, 0, N_EVENTS'(1), "precnt");
    reset_burst();
    repeat (3) cyc(0, 12'hB00, 0, 0, 0, '0, "post_rst");

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (n == 750) reset_burst();
      cyc(($urandom_range(0, 3) == 0), pick_addr(), pick_data(), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0), N_EVENTS'($urandom), "rand");
    end

    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain pending actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_counters.md
# csr_counters

Parametrised machine-mode counter CSR bank: `mcycle`, `minstret`, `N_HPM` hardware performance counters with per-counter event selection, `mcountinhibit`, and user read-only shadows. It is the next generation of the core's cycle/instret CSR unit. It sits beside the decode/execute stage and serves the CSR instruction datapath through a 12-bit address and a single-cycle read/write port. Each counter is `CNT_W` bits wide and is accessed as low and high 32-bit halves.

## Interface
- `N_HPM`, default 4: number of hpm counters, range 1..29, mapped as mhpmcounter3..(3+N_HPM-1).
- `N_EVENTS`, default 8: width of the `events` input vector.
- `CNT_W`, default 64: counter width, range 33..64.
- `clock` in 1: the only clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `wen` in 1: CSR write strobe for `addr`.
- `addr` in 12: CSR address.
- `wdata` in 32: write data.
- `rdata` out 32: read data, combinational from `addr`.
- `is_instret` in 1: one instruction retires this cycle.
- `halt` in 1: core halted (ebreak); freezes `mcycle`.
- `events` in N_EVENTS: per-cycle event pulses.
- `ovf_irq` out 1: counter-overflow interrupt request.

## Operation
- Address map:
  - mcycle B00/B80, minstret B02/B82.
  - mhpmcounter(3+i) at B03+i (low half) and B83+i (high half).
  - mcountinhibit 320; mhpmevent(3+i) at 323+i.
  - Read-only shadows C00/C80, C02/C82, C03+i/C83+i return the same data as the B-page addresses.
  - Writes to shadows and to any unmapped address are ignored. Unmapped reads return 0.
- High-half reads return counter bits [CNT_W-1:32], zero-extended. High-half writes keep wdata[CNT_W-33:0].
- Counter increment rules, evaluated every cycle:
  - `mcycle` increments when `!halt && !inhibit[0]`.
  - `minstret` increments when `is_instret && !inhibit[2]`.
  - hpm counter i increments when `sel_i != 0`, `sel_i <= N_EVENTS`, `events[sel_i-1]` is high, and `!inhibit[3+i]`.
  - `sel_i` is mhpmevent bits [EV_W-1:0], with EV_W = $clog2(N_EVENTS+1). Selector values above N_EVENTS count nothing.
- Writes:
  - A write to one half of a counter replaces that half. The other half holds its value.
  - There is no increment on the written counter in that cycle. The write wins over the increment.
  - Counters wrap from all-ones to 0.
- mcountinhibit storage:
  - Bits 0, 2 and 3..3+N_HPM-1 are writable.
  - Bit 1 and all unimplemented bits read 0.
- mhpmevent storage:
  - Bits [EV_W-1:0] are writable.
  - Bit 31 is OF (see Configuration).
  - All other bits read 0.
- Reset values:
  - All counters, selectors, mcountinhibit and OF bits are 0.
  - `ovf_irq` is 0.
  - `rdata` follows from these zeroed registers.
- Reset asserted mid-operation clears all state asynchronously. This includes a write that is in flight.

## Timing
- Reads are zero-latency. `rdata` reflects register state before this cycle's clock edge.
- A read and write of the same address in the same cycle returns the old value.
- A written value is visible on the next cycle's read.
- Increments take effect at the clock edge and are visible the next cycle.
- A mcountinhibit or mhpmevent write affects counting from the next cycle onward. The write-cycle increment uses the old settings.
- `halt`, `is_instret` and `events` are sampled in the cycle they are high. Each qualifies at most +1 per counter per cycle.
- `ovf_irq` is registered state: it asserts the cycle after the wrapping edge.

## Configuration
- `CSR_CNT_OVF_EN` defined:
  - An hpm counter wrapping via increment sets its sticky OF bit (mhpmevent bit 31).
  - `ovf_irq` = OR of all OF bits.
  - OF is written directly by mhpmevent writes through wdata[31].
  - If a wrap and an mhpmevent write occur in the same cycle, the written value wins.
  - A counter write in the wrap cycle suppresses the wrap, so OF is not set.
  - `mcycle` and `minstret` never set OF.
- `CSR_CNT_OVF_EN` undefined:
  - No OF storage; bit 31 reads 0.
  - `ovf_irq` is tied to 0.

## Test plan
- Release reset, idle 10 cycles with halt=0 -> read B00 = 10, B02 = 0, C00 = B00 value, every mhpmcounter = 0.
- Write B80=0x1 then B00=0xFFFFFFFE, hold halt=1 for 3 cycles -> B00 stays 0xFFFFFFFE. After releasing halt for 3 cycles, B00 = 0x00000001 and B80 = 0x2.
- Write 323=2 (select events[1]), pulse events[1] 5 times and events[0] 4 times -> B03 = 5. Write 320=0x8, pulse events[1] 3 times -> B03 still 5.
- Retire an instruction every cycle while writing B02=100 in cycle k -> read B02 = 100 at k+1 and 101 at k+2.
- With CSR_CNT_OVF_EN: set B83=0xFFFFFFFF, B03=0xFFFFFFFF, select an event and pulse it once -> B03 = 0, ovf_irq = 1 the next cycle, read 323 = 0x80000001. Write 323=1 -> ovf_irq drops the next cycle.
- Write C00=5, read unmapped 0x7C0 -> both reads return the unchanged mcycle value and 0 respectively. Assert reset_n low mid-count -> all reads return 0 immediately.
